keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver: scans a 4x4 hex keypad (Digilent PmodKYPD style) by strobing rows and reading columns.
- Debounces key presses and emits one 4-bit hex code per press.
- Shifts each accepted code into a 32-bit entry register, so the SoC can take a typed hex word and show it on the display.
- Single clock domain. Scan timing comes from an internal enable tick; no derived clocks.

Parameters:
- SCAN_DIV, 50000, clk cycles per row dwell (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, number of consecutive identical full-scan results needed to change press/release state; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- row  out  4  row drive, active-low one-hot (0 = row strobed)
- col  in  4  column sense, active-low (external pull-ups), asynchronous
- clear  in  1  synchronous clear of num
- key_code  out  4  hex code of the last accepted key
- key_valid  out  1  one-cycle pulse when a new key is accepted
- key_held  out  1  high while the debounced state is PRESSED
- num  out  32  accumulated entry, newest digit in [3:0]

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_held=0, num=0. Internal state: FSM=IDLE, row index=0, tick counter=0, debounce counter=0.
- col passes through a 2-flop synchronizer before use.
- Row timing:
  - Tick counter runs 0..SCAN_DIV-1. row = ~(4'b0001 << r).
  - When the counter reaches SCAN_DIV-1, latch the synchronized col for row r, then advance r (wraps 3->0).
  - Row r is sampled SCAN_DIV-1 cycles after it is driven low, which covers synchronizer latency.
- Scan result, evaluated one cycle after the row-3 sample:
  - NONE: no bit active.
  - SINGLE(code): exactly one bit active across all 16 samples.
  - MULTI: two or more bits active.
- Keymap, row r / col c -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce:
  - If this scan's result equals the previous scan's result (including the code), increment the counter, saturating at DEBOUNCE_SCANS. Otherwise set it to 1.
  - The result is stable when the counter equals DEBOUNCE_SCANS.
- FSM IDLE:
  - On a stable SINGLE(code), go to PRESSED in the cycle after evaluation.
  - Same cycle: key_valid=1 for exactly one cycle, key_code=code, key_held=1, num={num[27:0],code}.
  - Stable MULTI or NONE: stay in IDLE, no output.
- FSM PRESSED:
  - On a stable NONE, go to IDLE and set key_held=0.
  - SINGLE (any code) or MULTI: stay in PRESSED. There is no auto-repeat, and rolling to a second key without releasing the first is ignored.
- After an accept or release, the debounce counter keeps running. Re-acceptance requires leaving PRESSED first.
- num shifting: the top digit is discarded on each shift. After 8 digits the oldest is lost, with no saturation.
- clear: num=0 on the next cycle. If clear and an accept occur in the same cycle, clear wins: num=0, while key_valid and key_code still update.
- Reset mid-scan or mid-press: everything returns to reset values immediately. A key still held after reset is accepted once it becomes stable, after DEBOUNCE_SCANS full scans.
- Latency from a clean press to key_valid: at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.

Decomposition:
- Shared package keypad_pkg:
  - FSM state enum {IDLE, PRESSED}.
  - Scan-result kind enum {NONE, SINGLE, MULTI}.
  - The 16-entry keymap constant.
- Sub-module sync_2ff (reusable, parameterized width), used for col.
- Keymap, scan, debounce and FSM stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan period 16 cycles):
- Reset, no keys (col=4'hF) for 200 cycles -> row cycles 1110,1101,1011,0111 with 4 cycles per row; key_valid never asserted; num=0.
- Model holds key '5' (col[1] low while row[1] low) -> exactly one key_valid pulse with key_code=4'h5 within 3*16+3 cycles; num=32'h5; key_held=1 until release, then 0 after 2 clean scans.
- Key '7' press with 3 bounce toggles in the first scan, then held -> exactly one key_valid with key_code=4'h7; no extra pulses.
- Enter 1,2,3,A,B,C,D,E,F with releases in between -> num=32'h23ABCDEF and 9 key_valid pulses.
- Press '1' and '2' together (MULTI) from IDLE -> no key_valid. Press '0', then add 'D' while holding, release 'D', release '0' -> exactly one key_valid with code 4'h0.
- Assert clear in the same cycle as the accept of '9' -> num=0, key_valid=1, key_code=4'h9. Assert rst mid-press -> outputs at reset values; key re-accepted after 2 stable scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 hex keypad scanner.
package keypad_pkg;

    // Debounced key state.
    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    // Classification of one complete 16-position scan.
    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } kind_t;

    // Hex code for each position, index = row*4 + col, entry 0 in the low nibble.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] keymap_lookup(input logic [3:0] idx);
        return KEYMAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second gives it a full cycle to resolve.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so q takes meta's value from before the edge.
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row strobing, scan classification, debounce,
// press/release FSM and a 32-bit hex entry shift register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] num
);

    localparam int                TICK_W    = $clog2(SCAN_DIV);
    localparam int                DB_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_STABLE = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

    logic [3:0]        col_sync;     // still active-low
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        row_idx;
    logic [15:0]       hits;         // active-high, bit row*4 + col
    logic              eval_pending; // high for the cycle after the row-3 sample

    logic [3:0]        hit_idx;
    kind_t             cur_kind;
    logic [3:0]        cur_code;
    kind_t             prev_kind;
    logic [3:0]        prev_code;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_next;
    logic              stable;

    state_t            state;
    state_t            state_next;
    logic              accept;

    // Columns are idle-high, so the synchronizer resets to "no key".
    sync_2ff #(
        .WIDTH    (4),
        .RESET_VAL(4'hF)
    ) u_col_sync (
        .clk(clk),
        .rst(rst),
        .d  (col),
        .q  (col_sync)
    );

    assign row      = ~(4'b0001 << row_idx);
    assign key_held = (state == PRESSED);

    // Row dwell timing: sample columns at the end of each dwell, then move to the next row.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt     <= '0;
            row_idx      <= '0;
            hits         <= '0;
            eval_pending <= 1'b0;
        end else begin
            eval_pending <= 1'b0;
            if (tick_cnt == TICK_LAST) begin
                tick_cnt                   <= '0;
                hits[{row_idx, 2'b00} +: 4] <= ~col_sync;
                row_idx                    <= row_idx + 2'd1;
                eval_pending               <= (row_idx == 2'd3);
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Classify the completed scan; the code is forced to 0 unless exactly one key is seen.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves a latch.
        hit_idx  = 4'h0;
        cur_kind = MULTI;
        cur_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (hits[i]) hit_idx = 4'(i);
        end
        if (hits == 16'h0000) begin
            cur_kind = NONE;
        end else if ((hits & (hits - 16'd1)) == 16'h0000) begin
            cur_kind = SINGLE;
            cur_code = keymap_lookup(hit_idx);
        end
    end

    // Count consecutive identical scan results, saturating at the stable threshold.
    always_comb begin
        db_next = DB_ONE;
        if ((cur_kind == prev_kind) && (cur_code == prev_code)) begin
            db_next = (db_cnt == DB_STABLE) ? DB_STABLE : db_cnt + DB_ONE;
        end
        stable = eval_pending && (db_next == DB_STABLE);
    end

    // Remember the last scan result and run count; updated once per full scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_kind <= NONE;
            prev_code <= 4'h0;
            db_cnt    <= '0;
        end else if (eval_pending) begin
            prev_kind <= cur_kind;
            prev_code <= cur_code;
            db_cnt    <= db_next;
        end
    end

    // Debounced key state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept a stable single key from IDLE; leave PRESSED only on a stable empty scan.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (stable && (cur_kind == SINGLE)) begin
                    state_next = PRESSED;
                    accept     = 1'b1;
                end
            end
            PRESSED: begin
                if (stable && (cur_kind == NONE)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered key outputs and the entry shift register; clear beats a same-cycle shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            num       <= '0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= cur_code;
            end
            if (clear) begin
                num <= '0;
            end else if (accept) begin
                num <= {num[27:0], cur_code};
            end
        end
    end

endmodule
